// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU and the LSU,
// with a registered write stage and a per-register pending-write scoreboard for issue.
module rf_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [4:0]            alu_rd_addr,
    input  logic [DATA_WIDTH-1:0] alu_rd_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [4:0]            lsu_rd_addr,
    input  logic [DATA_WIDTH-1:0] lsu_rd_data,
    output logic                  rf_wr_en,
    output logic [4:0]            rf_rd_addr,
    output logic [DATA_WIDTH-1:0] rf_rd_data,
    input  logic                  issue_valid,
    input  logic [4:0]            issue_rd_addr,
    input  logic [4:0]            chk_rs1_addr,
    input  logic [4:0]            chk_rs2_addr,
    input  logic [4:0]            chk_rd_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  rd_busy,
    output logic [5:0]            pend_cnt
);

    // Register 0 is hardwired zero and registers beyond NUM_REGS do not exist.
    localparam logic [31:0] TRACK_MASK = (NUM_REGS >= 32) ? 32'hFFFF_FFFE :
                                         (((32'h1 << NUM_REGS) - 32'h1) & 32'hFFFF_FFFE);

    typedef enum logic {
        PRIO_ALU = 1'b0,
        PRIO_LSU = 1'b1
    } prio_e;

    function automatic logic [31:0] addr_onehot(input logic en, input logic [4:0] addr);
        logic [31:0] vec;
        vec = 32'h0;
        if (en) begin
            vec[addr] = 1'b1;
        end else begin
            vec = 32'h0;
        end
        return vec;
    endfunction

    function automatic logic [5:0] cnt_step(input logic [5:0] cnt, input logic inc, input logic dec);
        logic [5:0] res;
        case ({inc, dec})
            2'b10:   res = cnt + 6'd1;
            2'b01:   res = cnt - 6'd1;
            default: res = cnt;
        endcase
        return res;
    endfunction

    prio_e                  prio_r;
    prio_e                  prio_nxt_s;
    logic                   grant_alu_s;
    logic                   grant_lsu_s;
    logic                   xfer_s;
    logic [4:0]             xfer_addr_s;
    logic [DATA_WIDTH-1:0]  xfer_data_s;
    logic                   wr_en_r;
    logic [4:0]             wr_addr_r;
    logic [DATA_WIDTH-1:0]  wr_data_r;
    logic [31:0]            sb_r;
    logic [31:0]            sb_nxt_s;
    logic [31:0]            set_vec_s;
    logic [31:0]            clr_vec_s;
    logic                   set_en_s;
    logic                   clr_en_s;
    logic                   inc_s;
    logic                   dec_s;
    logic [5:0]             cnt_r;
    logic [5:0]             cnt_nxt_s;

    // Arbitration: a lone requester always wins; a contest goes to the pointer and flips it.
    always_comb begin
        grant_alu_s = 1'b0;
        grant_lsu_s = 1'b0;
        prio_nxt_s  = prio_r;
        if (alu_valid && lsu_valid) begin
            if (prio_r == PRIO_ALU) begin
                grant_alu_s = 1'b1;
                prio_nxt_s  = PRIO_LSU;
            end else begin
                grant_lsu_s = 1'b1;
                prio_nxt_s  = PRIO_ALU;
            end
        end else begin
            grant_alu_s = alu_valid;
            grant_lsu_s = lsu_valid;
        end
    end

    // Select the winning requester's payload for the write stage.
    always_comb begin
        xfer_s = grant_alu_s | grant_lsu_s;
        if (grant_lsu_s) begin
            xfer_addr_s = lsu_rd_addr;
            xfer_data_s = lsu_rd_data;
        end else begin
            xfer_addr_s = alu_rd_addr;
            xfer_data_s = alu_rd_data;
        end
    end

    // Scoreboard next state: a clear is applied first so a same-address issue wins.
    always_comb begin
        set_en_s  = issue_valid && (issue_rd_addr != 5'd0) && TRACK_MASK[issue_rd_addr];
        clr_en_s  = wr_en_r && TRACK_MASK[wr_addr_r];
        set_vec_s = addr_onehot(set_en_s, issue_rd_addr);
        clr_vec_s = addr_onehot(clr_en_s, wr_addr_r);
        sb_nxt_s  = ((sb_r & ~clr_vec_s) | set_vec_s) & TRACK_MASK;
        inc_s     = set_en_s && !sb_r[issue_rd_addr];
        dec_s     = clr_en_s && sb_r[wr_addr_r] &&
                    !(set_en_s && (issue_rd_addr == wr_addr_r));
        cnt_nxt_s = cnt_step(cnt_r, inc_s, dec_s);
    end

    // Round-robin priority pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_r <= PRIO_ALU;
        end else begin
            prio_r <= prio_nxt_s;
        end
    end

    // Registered write port; writes to register 0 are consumed without a write strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= 5'd0;
            wr_data_r <= {DATA_WIDTH{1'b0}};
        end else begin
            wr_en_r <= xfer_s && (xfer_addr_s != 5'd0);
            if (xfer_s && (xfer_addr_s != 5'd0)) begin
                wr_addr_r <= xfer_addr_s;
                wr_data_r <= xfer_data_s;
            end else begin
                wr_addr_r <= wr_addr_r;
                wr_data_r <= wr_data_r;
            end
        end
    end

    // Pending-write bits and their running population count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_r  <= 32'h0;
            cnt_r <= 6'd0;
        end else begin
            sb_r  <= sb_nxt_s;
            cnt_r <= cnt_nxt_s;
        end
    end

    assign alu_ready  = grant_alu_s;
    assign lsu_ready  = grant_lsu_s;
    assign rf_wr_en   = wr_en_r;
    assign rf_rd_addr = wr_addr_r;
    assign rf_rd_data = wr_data_r;
    assign pend_cnt   = cnt_r;
    assign rs1_busy   = sb_r[chk_rs1_addr];
    assign rs2_busy   = sb_r[chk_rs2_addr];
    assign rd_busy    = sb_r[chk_rd_addr];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus random traffic, with a
// reference model and a queue of expected register-file writes.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd_addr;
    logic [31:0] alu_rd_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd_addr;
    logic [31:0] lsu_rd_data;
    logic        rf_wr_en;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic        issue_valid;
    logic [4:0]  issue_rd_addr;
    logic [4:0]  chk_rs1_addr;
    logic [4:0]  chk_rs2_addr;
    logic [4:0]  chk_rd_addr;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rd_busy;
    logic [5:0]  pend_cnt;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          n_checks;
    int          n_pass;
    logic        m_ptr;
    logic [31:0] m_sb;
    logic [31:0] m_sb_nxt;
    logic        m_wr_en;
    logic [4:0]  m_wr_addr;
    logic        m_ga;
    logic        m_gl;
    logic        a_acc;
    logic        l_acc;

    rf_wb_arbiter #(.DATA_WIDTH(32), .NUM_REGS(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd_addr(alu_rd_addr), .alu_rd_data(alu_rd_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd_addr(lsu_rd_addr), .lsu_rd_data(lsu_rd_data),
        .rf_wr_en(rf_wr_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .issue_valid(issue_valid), .issue_rd_addr(issue_rd_addr),
        .chk_rs1_addr(chk_rs1_addr), .chk_rs2_addr(chk_rs2_addr), .chk_rd_addr(chk_rd_addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy), .pend_cnt(pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: round-robin grant and scoreboard next state.
    always_comb begin
        m_ga     = alu_valid && (!lsu_valid || !m_ptr);
        m_gl     = lsu_valid && (!alu_valid || m_ptr);
        m_sb_nxt = m_sb;
        if (m_wr_en) m_sb_nxt[m_wr_addr] = 1'b0;
        if (issue_valid && (issue_rd_addr != 5'd0)) m_sb_nxt[issue_rd_addr] = 1'b1;
    end

    // Reference model state.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr     <= 1'b0;
            m_sb      <= 32'h0;
            m_wr_en   <= 1'b0;
            m_wr_addr <= 5'd0;
        end else begin
            m_sb      <= m_sb_nxt;
            if (alu_valid && lsu_valid) m_ptr <= !m_ptr;
            m_wr_en   <= (m_ga && (alu_rd_addr != 5'd0)) || (m_gl && (lsu_rd_addr != 5'd0));
            m_wr_addr <= m_ga ? alu_rd_addr : lsu_rd_addr;
        end
    end

    // Writes already in flight are dropped by reset.
    always @(negedge rst_n) exp_q.delete();

    // Mid-cycle monitor: compare outputs to the model, pop delivered writes, push new grants.
    always @(negedge clk) begin
        if (rf_wr_en) begin
            check_eq("wr_expected", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
                check_eq("wr_addr", {27'd0, rf_rd_addr}, {27'd0, exp_q[0].addr});
                check_eq("wr_data", rf_rd_data, exp_q[0].data);
                void'(exp_q.pop_front());
            end
        end
        check_eq("wr_en", {31'd0, rf_wr_en}, {31'd0, m_wr_en});
        check_eq("rs1_busy", {31'd0, rs1_busy}, {31'd0, m_sb[chk_rs1_addr]});
        check_eq("rs2_busy", {31'd0, rs2_busy}, {31'd0, m_sb[chk_rs2_addr]});
        check_eq("rd_busy", {31'd0, rd_busy}, {31'd0, m_sb[chk_rd_addr]});
        check_eq("pend_cnt", {26'd0, pend_cnt}, $countones(m_sb));
        if (rst_n) begin
            check_eq("alu_ready", {31'd0, alu_ready}, {31'd0, m_ga});
            check_eq("lsu_ready", {31'd0, lsu_ready}, {31'd0, m_gl});
            if (m_ga && (alu_rd_addr != 5'd0)) exp_q.push_back({alu_rd_addr, alu_rd_data});
            if (m_gl && (lsu_rd_addr != 5'd0)) exp_q.push_back({lsu_rd_addr, lsu_rd_data});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one writeback request and hold it until accepted (bounded wait).
    task automatic wb_req(input bit use_lsu, input logic [4:0] a, input logic [31:0] d);
        bit got;
        got = 1'b0;
        if (use_lsu) begin
            lsu_valid = 1'b1; lsu_rd_addr = a; lsu_rd_data = d;
        end else begin
            alu_valid = 1'b1; alu_rd_addr = a; alu_rd_data = d;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (use_lsu ? lsu_ready : alu_ready) begin
                got = 1'b1;
                break;
            end
        end
        check_eq(use_lsu ? "lsu_accept" : "alu_accept", {31'd0, got}, 32'd1);
        @(posedge clk);
        #1;
        if (use_lsu) lsu_valid = 1'b0;
        else alu_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_pass = 0;
        rst_n = 1'b0;
        alu_valid = 1'b1; alu_rd_addr = 5'd4; alu_rd_data = 32'h0BAD_F00D;
        lsu_valid = 1'b0; lsu_rd_addr = 5'd0; lsu_rd_data = 32'h0;
        issue_valid = 1'b0; issue_rd_addr = 5'd0;
        chk_rs1_addr = 5'd0; chk_rs2_addr = 5'd0; chk_rd_addr = 5'd0;

        // Reset held with a request pending.
        repeat (3) cyc();
        check_eq("rst_wr_en", {31'd0, rf_wr_en}, 32'd0);
        check_eq("rst_pend", {26'd0, pend_cnt}, 32'd0);
        check_eq("rst_busy", {29'd0, rs1_busy, rs2_busy, rd_busy}, 32'd0);
        alu_valid = 1'b0;
        rst_n = 1'b1;
        cyc();

        // Issue rd=5, then ALU writes it back.
        issue_valid = 1'b1; issue_rd_addr = 5'd5;
        cyc();
        issue_valid = 1'b0; chk_rs1_addr = 5'd5;
        #1;
        check_eq("rs1_busy_set", {31'd0, rs1_busy}, 32'd1);
        check_eq("pend_one", {26'd0, pend_cnt}, 32'd1);
        wb_req(1'b0, 5'd5, 32'hDEAD_BEEF);
        check_eq("wr5_en", {31'd0, rf_wr_en}, 32'd1);
        check_eq("wr5_addr", {27'd0, rf_rd_addr}, 32'd5);
        check_eq("wr5_data", rf_rd_data, 32'hDEAD_BEEF);
        check_eq("rs1_busy_until_write", {31'd0, rs1_busy}, 32'd1);
        cyc();
        check_eq("rs1_busy_clr", {31'd0, rs1_busy}, 32'd0);
        check_eq("pend_zero", {26'd0, pend_cnt}, 32'd0);

        // Contested requests alternate ALU, LSU, ALU, LSU.
        alu_valid = 1'b1; alu_rd_addr = 5'd3; alu_rd_data = 32'hAAAA_0003;
        lsu_valid = 1'b1; lsu_rd_addr = 5'd7; lsu_rd_data = 32'h5555_0007;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("rr_alu_grant", {31'd0, alu_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check_eq("rr_lsu_grant", {31'd0, lsu_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
            cyc();
            check_eq("rr_wr_en", {31'd0, rf_wr_en}, 32'd1);
            check_eq("rr_wr_addr", {27'd0, rf_rd_addr}, (k % 2 == 0) ? 32'd3 : 32'd7);
            check_eq("rr_wr_data", rf_rd_data, (k % 2 == 0) ? 32'hAAAA_0003 : 32'h5555_0007);
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        cyc();

        // Writeback to r0 is consumed silently; issue to r0 is ignored.
        wb_req(1'b1, 5'd0, 32'h0000_1234);
        check_eq("r0_no_write", {31'd0, rf_wr_en}, 32'd0);
        issue_valid = 1'b1; issue_rd_addr = 5'd0; chk_rs1_addr = 5'd0;
        cyc();
        issue_valid = 1'b0;
        check_eq("r0_pend", {26'd0, pend_cnt}, 32'd0);
        check_eq("r0_busy", {31'd0, rs1_busy}, 32'd0);

        // Same-edge clear and re-issue of r9: set wins.
        issue_valid = 1'b1; issue_rd_addr = 5'd9;
        cyc();
        issue_valid = 1'b0;
        wb_req(1'b0, 5'd9, 32'h0000_0909);
        check_eq("r9_write_now", {31'd0, rf_wr_en}, 32'd1);
        issue_valid = 1'b1; issue_rd_addr = 5'd9;
        cyc();
        issue_valid = 1'b0; chk_rd_addr = 5'd9;
        #1;
        check_eq("r9_still_busy", {31'd0, rd_busy}, 32'd1);
        check_eq("r9_pend", {26'd0, pend_cnt}, 32'd1);

        // Fill every tracked register.
        for (int a = 1; a < 32; a++) begin
            issue_valid = 1'b1; issue_rd_addr = 5'(a);
            cyc();
        end
        issue_valid = 1'b0;
        check_eq("fill_pend", {26'd0, pend_cnt}, 32'd31);
        for (int a = 0; a < 32; a++) begin
            chk_rs1_addr = 5'(a); chk_rs2_addr = 5'(a); chk_rd_addr = 5'(a);
            #1;
            check_eq("fill_busy", {29'd0, rs1_busy, rs2_busy, rd_busy}, (a == 0) ? 32'd0 : 32'd7);
        end
        cyc();
        issue_valid = 1'b1; issue_rd_addr = 5'd31;
        cyc();
        check_eq("fill_no_wrap", {26'd0, pend_cnt}, 32'd31);

        // Asynchronous reset between clock edges.
        chk_rs1_addr = 5'd5;
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("arst_pend", {26'd0, pend_cnt}, 32'd0);
        check_eq("arst_busy", {31'd0, rs1_busy}, 32'd0);
        check_eq("arst_wr_en", {31'd0, rf_wr_en}, 32'd0);
        issue_valid = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();

        // Random traffic obeying the hold-until-ready protocol.
        for (int c = 0; c < 300; c++) begin
            if (!alu_valid && ($urandom_range(0, 2) == 0)) begin
                alu_valid = 1'b1; alu_rd_addr = 5'($urandom_range(0, 31)); alu_rd_data = $urandom();
            end
            if (!lsu_valid && ($urandom_range(0, 2) == 0)) begin
                lsu_valid = 1'b1; lsu_rd_addr = 5'($urandom_range(0, 31)); lsu_rd_data = $urandom();
            end
            issue_valid = ($urandom_range(0, 3) == 0);
            issue_rd_addr = 5'($urandom_range(0, 31));
            chk_rs1_addr = 5'($urandom_range(0, 31));
            chk_rs2_addr = 5'($urandom_range(0, 31));
            chk_rd_addr = 5'($urandom_range(0, 31));
            @(negedge clk);
            a_acc = alu_valid && alu_ready;
            l_acc = lsu_valid && lsu_ready;
            cyc();
            if (a_acc) alu_valid = 1'b0;
            if (l_acc) lsu_valid = 1'b0;
        end
        issue_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            a_acc = alu_valid && alu_ready;
            l_acc = lsu_valid && lsu_ready;
            cyc();
            if (a_acc) alu_valid = 1'b0;
            if (l_acc) lsu_valid = 1'b0;
        end
        check_eq("drain_valids", {30'd0, alu_valid, lsu_valid}, 32'd0);
        repeat (3) cyc();
        check_eq("queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
